piece_dropper: RTL and testbench

Player-controlled Connect Four piece placer. Keycodes move a hovering piece across the board columns, and a drop key animates the piece falling one step per frame into the lowest empty cell of the chosen column. The block tracks column fill heights, alternates players, and reports each completed placement. It drives the sprite coordinates of the active piece; the static per-cell position generators sit beside it in the board-drawing path.

---
 rtl/dropper_pkg.sv | 23 ++
 rtl/column_heights.sv | 45 ++++
 rtl/piece_dropper.sv | 172 +++++++++++++++++
 tb/tb_piece_dropper.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dropper_pkg.sv
// Shared definitions for the Connect Four piece dropper: FSM states,
// HID keycodes of the three control keys and the visible screen bounds.
package dropper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        LAND = 2'd2
    } state_e;

    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_DROP  = 8'h51;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // True when the keycode is one of the keys this block reacts to.
    function automatic logic is_ctrl_key(input logic [7:0] key);
        return (key == KEY_LEFT) || (key == KEY_RIGHT) || (key == KEY_DROP);
    endfunction

endpackage

// File: rtl/column_heights.sv
// Per-column fill counters for the board. One column can be incremented
// per cycle; full flags and the board-full summary derive from the counters.
module column_heights #(
    parameter  int COLS = 7,
    parameter  int ROWS = 6,
    localparam int CW   = $clog2(COLS),
    localparam int RW   = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_i,
    input  logic [CW-1:0]         inc_col_i,
    output logic [COLS-1:0][RW:0] height_o,
    output logic [COLS-1:0]       full_o,
    output logic                  board_full_o
);

    logic [COLS-1:0][RW:0] height_q;

    // Count one piece into the addressed column; a full column never wraps.
    // NOTE: the counters are a handful of flops, not a RAM, so they take the
    // reset like any other state; a real memory array would be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            height_q <= '0;
        end else if (inc_i && !full_o[inc_col_i]) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples pre-edge values regardless of block order.
            height_q[inc_col_i] <= height_q[inc_col_i] + 1'b1;
        end
    end

    // A column is full once it holds ROWS pieces.
    always_comb begin
        // NOTE: default first so no path through the block can infer a latch.
        full_o = '0;
        for (int c = 0; c < COLS; c++) begin
            full_o[c] = (height_q[c] == (RW + 1)'(ROWS));
        end
    end

    assign height_o     = height_q;
    assign board_full_o = &full_o;

endmodule

// File: rtl/piece_dropper.sv
// Connect Four piece placer: moves the hovering piece between columns,
// animates the drop into the lowest free cell, alternates players and
// reports each landing. Optional macro DROPPER_WRAP_EN makes column
// selection wrap around at the board edges instead of clamping.
module piece_dropper
    import dropper_pkg::*;
#(
    parameter  int COLS      = 7,
    parameter  int ROWS      = 6,
    parameter  int ORIGIN_X  = 75,
    parameter  int ORIGIN_Y  = 75,
    parameter  int PITCH     = 75,
    parameter  int HOVER_Y   = 0,
    parameter  int DROP_STEP = 15,
    parameter  int START_COL = 3,
    localparam int CW        = $clog2(COLS),
    localparam int RW        = $clog2(ROWS)
) (
    input  logic          frame_clk,
    input  logic          Reset,
    input  logic [7:0]    keycode,
    output logic [9:0]    PieceX,
    output logic [9:0]    PieceY,
    output logic [CW-1:0] col_sel,
    output logic          player,
    output logic          busy,
    output logic          placed,
    output logic [CW-1:0] place_col,
    output logic [RW-1:0] place_row,
    output logic          col_full,
    output logic          board_full
);

    // Refuse to build a board that does not fit on screen.
    if ((ORIGIN_X + (COLS - 1) * PITCH >= SCREEN_W) ||
        (ORIGIN_Y + (ROWS - 1) * PITCH >= SCREEN_H) || (DROP_STEP < 1)) begin : g_bad_geometry
        $fatal(1, "piece_dropper: board exceeds the screen or DROP_STEP < 1");
    end

    state_e                state_q, state_d;
    logic [7:0]            prev_key_q;
    logic [CW-1:0]         col_q, col_d, place_col_q, place_col_d;
    logic [RW-1:0]         tgt_row_q, tgt_row_d, place_row_q, place_row_d;
    logic [9:0]            px_q, px_d, py_q, py_d, tgt_y_q, tgt_y_d;
    logic                  player_q, player_d, placed_q, placed_d;
    logic                  col_full_q, col_full_d, busy_q, busy_d;
    logic                  key_event, inc;
    logic [COLS-1:0][RW:0] heights;
    logic [COLS-1:0]       full_flags;
    logic                  board_full_w;
    logic [RW:0]           height_sel;
    logic [10:0]           fall_sum;

    column_heights #(.COLS(COLS), .ROWS(ROWS)) u_heights (
        .clk          (frame_clk),
        .rst          (Reset),
        .inc_i        (inc),
        .inc_col_i    (col_q),
        .height_o     (heights),
        .full_o       (full_flags),
        .board_full_o (board_full_w)
    );

    // A key acts only on its first frame and only when nothing is falling.
    assign key_event  = (keycode != prev_key_q) && is_ctrl_key(keycode);
    assign height_sel = heights[col_q];
    // Eleven bits so a step past the bottom of the screen cannot wrap.
    assign fall_sum   = {1'b0, py_q} + 11'(DROP_STEP);

    // Next-state logic for column selection, drop animation and landing.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        py_d        = py_q;
        tgt_row_d   = tgt_row_q;
        tgt_y_d     = tgt_y_q;
        player_d    = player_q;
        place_col_d = place_col_q;
        place_row_d = place_row_q;
        placed_d    = 1'b0;
        col_full_d  = 1'b0;
        inc         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_event) begin
                    if (keycode == KEY_LEFT) begin
                        if (col_q != '0) col_d = col_q - 1'b1;
`ifdef DROPPER_WRAP_EN
                        else col_d = CW'(COLS - 1);
`endif
                    end else if (keycode == KEY_RIGHT) begin
                        if (col_q != CW'(COLS - 1)) col_d = col_q + 1'b1;
`ifdef DROPPER_WRAP_EN
                        else col_d = '0;
`endif
                    end else if (board_full_w || full_flags[col_q]) begin
                        col_full_d = 1'b1;
                    end else begin
                        tgt_row_d = RW'(ROWS - 1 - int'(height_sel));
                        tgt_y_d   = 10'(ORIGIN_Y + (ROWS - 1 - int'(height_sel)) * PITCH);
                        state_d   = FALL;
                    end
                end
            end
            FALL: begin
                if (fall_sum >= {1'b0, tgt_y_q}) begin
                    py_d        = tgt_y_q;
                    state_d     = LAND;
                    placed_d    = 1'b1;
                    place_col_d = col_q;
                    place_row_d = tgt_row_q;
                end else begin
                    py_d = fall_sum[9:0];
                end
            end
            LAND: begin
                inc      = 1'b1;
                player_d = ~player_q;
                py_d     = 10'(HOVER_Y);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        px_d   = 10'(ORIGIN_X + int'(col_d) * PITCH);
    end

    // Register every output and the dropper state.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            prev_key_q  <= '0;
            col_q       <= CW'(START_COL);
            px_q        <= 10'(ORIGIN_X + START_COL * PITCH);
            py_q        <= 10'(HOVER_Y);
            tgt_row_q   <= '0;
            tgt_y_q     <= '0;
            player_q    <= 1'b0;
            placed_q    <= 1'b0;
            col_full_q  <= 1'b0;
            busy_q      <= 1'b0;
            place_col_q <= '0;
            place_row_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_key_q  <= keycode;
            col_q       <= col_d;
            px_q        <= px_d;
            py_q        <= py_d;
            tgt_row_q   <= tgt_row_d;
            tgt_y_q     <= tgt_y_d;
            player_q    <= player_d;
            placed_q    <= placed_d;
            col_full_q  <= col_full_d;
            busy_q      <= busy_d;
            place_col_q <= place_col_d;
            place_row_q <= place_row_d;
        end
    end

    assign PieceX     = px_q;
    assign PieceY     = py_q;
    assign col_sel    = col_q;
    assign player     = player_q;
    assign busy       = busy_q;
    assign placed     = placed_q;
    assign place_col  = place_col_q;
    assign place_row  = place_row_q;
    assign col_full   = col_full_q;
    assign board_full = board_full_w;

endmodule

// File: tb/tb_piece_dropper.sv
// Self-checking bench for piece_dropper with default parameters. Landings
// are scored against a queue of expected (column, row) pairs filled when
// each DROP is driven; the remaining checks are inline in each test task.
module tb_piece_dropper;
    import dropper_pkg::*;

    localparam int COLS = 7;
    localparam int ROWS = 6;

    typedef struct packed {
        logic [2:0] col;
        logic [2:0] row;
    } place_t;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic [9:0] PieceX, PieceY;
    logic [2:0] col_sel, place_col, place_row;
    logic       player, busy, placed, col_full, board_full;

    place_t exp_q[$];
    int     errors = 0;
    int     checks = 0;
    int     model_h[COLS];
    int     cur_col;
    logic   model_player;

    piece_dropper dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .PieceX     (PieceX),
        .PieceY     (PieceY),
        .col_sel    (col_sel),
        .player     (player),
        .busy       (busy),
        .placed     (placed),
        .place_col  (place_col),
        .place_row  (place_row),
        .col_full   (col_full),
        .board_full (board_full)
    );

    always #5 frame_clk = ~frame_clk;

    // Scoreboard: every placed pulse must match the oldest expected landing.
    always @(negedge frame_clk) begin : sb_monitor
        place_t e;
        if (!Reset && placed === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL placed_unexpected: got col=%0d row=%0d, expected no landing",
                         place_col, place_row);
            end else begin
                e = exp_q.pop_front();
                if ({place_col, place_row} !== e) begin
                    errors++;
                    $display("FAIL placed_pos: got col=%0d row=%0d, expected col=%0d row=%0d",
                             place_col, place_row, e.col, e.row);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        Reset   = 1'b1;
        keycode = 8'h00;
        @(negedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;
        exp_q.delete();
        for (int c = 0; c < COLS; c++) model_h[c] = 0;
        cur_col      = 3;
        model_player = 1'b0;
    endtask

    // Press and release one key; returns at a negedge after the release.
    task automatic press_key(input logic [7:0] key);
        keycode = key;
        @(negedge frame_clk);
        keycode = 8'h00;
        @(negedge frame_clk);
    endtask

    task automatic move_to(input int c);
        while (cur_col > c) begin press_key(KEY_LEFT);  cur_col--; end
        while (cur_col < c) begin press_key(KEY_RIGHT); cur_col++; end
    endtask

    // Drop into the current column, expecting a landing on the model row.
    task automatic drop_ok();
        int n;
        exp_q.push_back(place_t'{col: 3'(cur_col), row: 3'(ROWS - 1 - model_h[cur_col])});
        keycode = KEY_DROP;
        @(negedge frame_clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_busy: got busy=%b, expected 1", busy);
        end
        keycode = 8'h00;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(negedge frame_clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL drop_timeout: busy still %b after %0d frames, expected 0", busy, n);
        end
        model_h[cur_col]++;
        model_player = ~model_player;
        checks++;
        if (player !== model_player || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drop_done: got player=%b pending=%0d, expected player=%b pending=0",
                     player, exp_q.size(), model_player);
        end
    endtask

    // Drop that must be rejected with a single col_full pulse.
    task automatic drop_rejected();
        keycode = KEY_DROP;
        @(negedge frame_clk);
        checks++;
        if (col_full !== 1'b1 || busy !== 1'b0 || placed !== 1'b0) begin
            errors++;
            $display("FAIL reject: got col_full=%b busy=%b placed=%b, expected 1 0 0",
                     col_full, busy, placed);
        end
        keycode = 8'h00;
        @(negedge frame_clk);
        checks++;
        if (col_full !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reject_pulse: got col_full=%b busy=%b, expected 0 0", col_full, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (PieceX !== 10'd300 || PieceY !== 10'd0 || col_sel !== 3'd3) begin
            errors++;
            $display("FAIL reset_pos: got X=%0d Y=%0d col=%0d, expected 300 0 3", PieceX, PieceY, col_sel);
        end
        checks++;
        if (player !== 1'b0 || busy !== 1'b0 || placed !== 1'b0 || col_full !== 1'b0 ||
            board_full !== 1'b0 || place_col !== 3'd0 || place_row !== 3'd0) begin
            errors++;
            $display("FAIL reset_flags: got player=%b busy=%b placed=%b col_full=%b board_full=%b pc=%0d pr=%0d, expected all 0",
                     player, busy, placed, col_full, board_full, place_col, place_row);
        end
    endtask

    task automatic test_move();
        int exp_cols[4] = '{4, 5, 6, 6};
        for (int i = 0; i < 4; i++) begin
            press_key(KEY_RIGHT);
            checks++;
            if (col_sel !== 3'(exp_cols[i])) begin
                errors++;
                $display("FAIL move_right%0d: got col=%0d, expected %0d", i, col_sel, exp_cols[i]);
            end
        end
        cur_col = 6;
        checks++;
        if (PieceX !== 10'd525) begin
            errors++;
            $display("FAIL move_x: got X=%0d, expected 525", PieceX);
        end
    endtask

    task automatic test_hold();
        keycode = KEY_LEFT;
        repeat (10) @(negedge frame_clk);
        keycode = 8'h00;
        @(negedge frame_clk);
        cur_col = 5;
        checks++;
        if (col_sel !== 3'd5 || PieceX !== 10'd450) begin
            errors++;
            $display("FAIL hold_left: got col=%0d X=%0d, expected 5 450", col_sel, PieceX);
        end
    endtask

    task automatic test_drop();
        int n;
        do_reset();
        exp_q.push_back(place_t'{col: 3'd3, row: 3'd5});
        keycode = KEY_DROP;
        @(negedge frame_clk);
        checks++;
        if (busy !== 1'b1 || PieceY !== 10'd0) begin
            errors++;
            $display("FAIL drop_start: got busy=%b Y=%0d, expected 1 0", busy, PieceY);
        end
        keycode = 8'h00;
        n = 0;
        while (PieceY !== 10'd450 && n < 40) begin
            @(negedge frame_clk);
            n++;
            checks++;
            if (PieceY !== 10'((15 * n > 450) ? 450 : 15 * n)) begin
                errors++;
                $display("FAIL fall_step%0d: got Y=%0d, expected %0d", n, PieceY, (15 * n > 450) ? 450 : 15 * n);
            end
        end
        checks++;
        if (n != 30 || placed !== 1'b1 || place_col !== 3'd3 || place_row !== 3'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL land: got frames=%0d placed=%b col=%0d row=%0d busy=%b, expected 30 1 3 5 1",
                     n, placed, place_col, place_row, busy);
        end
        @(negedge frame_clk);
        checks++;
        if (placed !== 1'b0 || player !== 1'b1 || PieceY !== 10'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_land: got placed=%b player=%b Y=%0d busy=%b, expected 0 1 0 0",
                     placed, player, PieceY, busy);
        end
        model_h[3]   = 1;
        model_player = 1'b1;
    endtask

    task automatic test_column_fill();
        do_reset();
        move_to(0);
        for (int i = 0; i < ROWS; i++) drop_ok();
        drop_rejected();
    endtask

    task automatic test_reset_midfall();
        int n;
        do_reset();
        exp_q.push_back(place_t'{col: 3'd3, row: 3'd5});
        keycode = KEY_DROP;
        @(negedge frame_clk);
        keycode = 8'h00;
        n = 0;
        while (PieceY !== 10'd225 && n < 40) begin
            @(negedge frame_clk);
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL midfall_reach: got Y=%0d, expected 225", PieceY);
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (PieceY !== 10'd0 || busy !== 1'b0 || placed !== 1'b0) begin
            errors++;
            $display("FAIL midfall_abort: got Y=%0d busy=%b placed=%b, expected 0 0 0", PieceY, busy, placed);
        end
        exp_q.delete();
        @(negedge frame_clk);
        Reset = 1'b0;
        for (int c = 0; c < COLS; c++) model_h[c] = 0;
        cur_col      = 3;
        model_player = 1'b0;
        drop_ok();
    endtask

    task automatic test_wrap();
        int exp_col;
        do_reset();
        move_to(0);
        press_key(KEY_LEFT);
`ifdef DROPPER_WRAP_EN
        exp_col = COLS - 1;
`else
        exp_col = 0;
`endif
        checks++;
        if (col_sel !== 3'(exp_col) || PieceX !== 10'(75 + 75 * exp_col)) begin
            errors++;
            $display("FAIL left_edge: got col=%0d X=%0d, expected %0d %0d",
                     col_sel, PieceX, exp_col, 75 + 75 * exp_col);
        end
        cur_col = exp_col;
    endtask

    task automatic test_board_full();
        do_reset();
        for (int c = 0; c < COLS; c++) begin
            move_to(c);
            for (int r = 0; r < ROWS; r++) begin
                if (c == COLS - 1 && r == ROWS - 1) begin
                    checks++;
                    if (board_full !== 1'b0) begin
                        errors++;
                        $display("FAIL board_early: got board_full=%b, expected 0", board_full);
                    end
                end
                drop_ok();
            end
        end
        checks++;
        if (board_full !== 1'b1) begin
            errors++;
            $display("FAIL board_full: got %b, expected 1", board_full);
        end
        move_to(3);
        drop_rejected();
    endtask

    initial begin
        Reset   = 1'b1;
        keycode = 8'h00;
        test_reset();
        test_move();
        test_hold();
        test_drop();
        test_column_fill();
        test_reset_midfall();
        test_wrap();
        test_board_full();
        repeat (2) @(negedge frame_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending landings, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
